// File: rtl/step_sequencer.sv
// step_sequencer: tempo-driven pattern player emitting registered note, gate and step index
module step_sequencer #(
  parameter int STEPS    = 8,
  parameter int NOTE_W   = 7,
  parameter int TICK_DIV = 6250000,
  parameter int GATE_LEN = 3125000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic [$clog2(STEPS):0]     length,
  input  logic                       wr_en,
  input  logic [$clog2(STEPS)-1:0]   wr_addr,
  input  logic [NOTE_W-1:0]          wr_note,
  input  logic                       wr_active,
  output logic [NOTE_W-1:0]          note,
  output logic                       gate,
  output logic [$clog2(STEPS)-1:0]   step_idx,
  output logic                       step_strobe,
  output logic                       running
);
  localparam int AW = $clog2(STEPS);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] GATE_LAST = TW'(GATE_LEN - 1);
  logic [0:0]        state;
  logic [TW-1:0]     tick;
  logic [NOTE_W-1:0] slot_note [STEPS];
  logic              slot_act  [STEPS];
  logic [LW-1:0]     len_eff;
  logic [AW-1:0]     next_idx;
  always_comb begin
    len_eff  = length == '0 ? LW'(1) : length > LW'(STEPS) ? LW'(STEPS) : length;
    next_idx = {1'b0, step_idx} >= len_eff - LW'(1) ? '0 : step_idx + AW'(1);
  end
  // loads below read the pre-edge slot contents, so a same-cycle write lands next pass
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STEPS; i++) begin
        slot_note[i] <= '0;
        slot_act[i]  <= 1'b0;
      end
    end else if (wr_en) begin
      slot_note[wr_addr] <= wr_note;
      slot_act[wr_addr]  <= wr_active;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || (state == RUN && !run)) begin
      state       <= IDLE;
      tick        <= '0;
      note        <= '0;
      gate        <= 1'b0;
      step_idx    <= '0;
      step_strobe <= 1'b0;
      running     <= 1'b0;
    end else if (state == IDLE) begin
      if (run) begin
        state       <= RUN;
        tick        <= '0;
        step_idx    <= '0;
        note        <= slot_note[0];
        gate        <= slot_act[0];
        step_strobe <= 1'b1;
        running     <= 1'b1;
      end
    end else if (tick == TICK_LAST) begin
      tick        <= '0;
      step_idx    <= next_idx;
      note        <= slot_note[next_idx];
      gate        <= slot_act[next_idx];
      step_strobe <= 1'b1;
    end else begin
      tick        <= tick + TW'(1);
      step_strobe <= 1'b0;
      if (tick == GATE_LAST) gate <= 1'b0;
    end
  end
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed scoreboard bench for step_sequencer (STEPS=4, TICK_DIV=4, GATE_LEN=2)
module tb_step_sequencer;
  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [2:0] length;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [6:0] wr_note;
  logic       wr_active;
  logic [6:0] note;
  logic       gate;
  logic [1:0] step_idx;
  logic       step_strobe;
  logic       running;
  logic [11:0] sb [$];
  logic [11:0] exp_v;
  logic [11:0] obs_v;
  int total = 0;
  int bad = 0;
  step_sequencer #(.STEPS(4), .NOTE_W(7), .TICK_DIV(4), .GATE_LEN(2)) dut (
    .clk(clk), .reset(reset), .run(run), .length(length),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note), .wr_active(wr_active),
    .note(note), .gate(gate), .step_idx(step_idx), .step_strobe(step_strobe), .running(running)
  );
  always #5 clk = ~clk;
  task automatic push(input int n, input bit g, input int i, input bit s, input bit r);
    sb.push_back({7'(n), g, 2'(i), s, r});
  endtask
  task automatic cyc(input string tag);
    @(posedge clk);
    #1;
    exp_v = sb.pop_front();
    obs_v = {note, gate, step_idx, step_strobe, running};
    total++;
    assert (obs_v === exp_v) else begin
      bad++;
      $error("FAIL %s got note=%0d gate=%b idx=%0d strobe=%b run=%b want note=%0d gate=%b idx=%0d strobe=%b run=%b",
             tag, obs_v[11:5], obs_v[4], obs_v[3:2], obs_v[1], obs_v[0],
             exp_v[11:5], exp_v[4], exp_v[3:2], exp_v[1], exp_v[0]);
    end
  endtask
  task automatic play_step(input string tag, input int n, input bit act, input int i);
    push(n, act, i, 1'b1, 1'b1);
    cyc({tag, "_t0"});
    wr_en = 1'b0;
    push(n, act, i, 1'b0, 1'b1);
    cyc({tag, "_t1"});
    push(n, 1'b0, i, 1'b0, 1'b1);
    cyc({tag, "_t2"});
    push(n, 1'b0, i, 1'b0, 1'b1);
    cyc({tag, "_t3"});
  endtask
  task automatic write_slot(input int a, input int n, input bit act);
    wr_en = 1'b1;
    wr_addr = 2'(a);
    wr_note = 7'(n);
    wr_active = act;
    push(0, 1'b0, 0, 1'b0, 1'b0);
    cyc("idle_write");
  endtask
  initial begin
    reset = 1'b1; run = 1'b0; length = 3'd4;
    wr_en = 1'b0; wr_addr = '0; wr_note = '0; wr_active = 1'b0;
    push(0, 1'b0, 0, 1'b0, 1'b0);
    cyc("reset");
    reset = 1'b0;
    write_slot(0, 60, 1'b1);
    write_slot(1, 62, 1'b1);
    write_slot(2, 64, 1'b0);
    write_slot(3, 65, 1'b1);
    wr_en = 1'b0;
    run = 1'b1;
    play_step("main0", 60, 1'b1, 0);
    play_step("main1", 62, 1'b1, 1);
    play_step("main2", 64, 1'b0, 2);
    play_step("main3", 65, 1'b1, 3);
    play_step("wrap0", 60, 1'b1, 0);
    push(62, 1'b1, 1, 1'b1, 1'b1);
    cyc("stop_pre");
    run = 1'b0;
    push(0, 1'b0, 0, 1'b0, 1'b0);
    cyc("stop");
    push(0, 1'b0, 0, 1'b0, 1'b0);
    cyc("stop_idle");
    run = 1'b1;
    play_step("restart0", 60, 1'b1, 0);
    length = 3'd0;
    play_step("len0_a", 60, 1'b1, 0);
    play_step("len0_b", 60, 1'b1, 0);
    length = 3'd7;
    play_step("len7_1", 62, 1'b1, 1);
    play_step("len7_2", 64, 1'b0, 2);
    play_step("len7_3", 65, 1'b1, 3);
    play_step("len7_0", 60, 1'b1, 0);
    length = 3'd4;
    play_step("shr1", 62, 1'b1, 1);
    play_step("shr2", 64, 1'b0, 2);
    play_step("shr3", 65, 1'b1, 3);
    length = 3'd2;
    play_step("shr_wrap", 60, 1'b1, 0);
    play_step("len2_1", 62, 1'b1, 1);
    play_step("len2_0", 60, 1'b1, 0);
    wr_en = 1'b1; wr_addr = 2'd1; wr_note = 7'd70; wr_active = 1'b1;
    play_step("coll_old", 62, 1'b1, 1);
    play_step("coll_0", 60, 1'b1, 0);
    play_step("coll_new", 70, 1'b1, 1);
    push(60, 1'b1, 0, 1'b1, 1'b1);
    cyc("rst_pre");
    reset = 1'b1;
    push(0, 1'b0, 0, 1'b0, 1'b0);
    cyc("rst_run");
    reset = 1'b0;
    play_step("cleared0", 0, 1'b0, 0);
    play_step("cleared1", 0, 1'b0, 1);
    play_step("cleared2", 0, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
